// File: rtl/alu_pkg.sv
// Shared definitions for the ID/EX decode stage: ALUControl codes, RV32I opcodes,
// operand/result select enums and the registered control bundle.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_e;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef struct packed {
    logic [3:0]      alu_control;
    src_a_e          src_a;
    src_b_e          src_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    result_src_e     result_src;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            branch_inv;
    logic            jump;
    logic            illegal;
  } ctrl_t;

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  // Shift immediates carry only the shamt so the ALU sees a clean amount.
  function automatic logic [XLEN-1:0] imm_shamt(input logic [31:0] instr);
    return {27'b0, instr[24:20]};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational RV32I decode of one instruction word into the ALU control bundle.
// The pc field is left zero; the pipeline stage fills it in.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl         = '0;
    illegal      = 1'b0;
    ctrl.rs1     = instr[19:15];
    ctrl.rs2     = instr[24:20];
    ctrl.rd      = instr[11:7];

    case (opcode)
      OPC_OP: begin
        ctrl.src_b     = SRC_B_RS2;
        ctrl.reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          ctrl.alu_control = {1'b0, funct3};
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          ctrl.alu_control = {1'b1, funct3};
        end else begin
          illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        ctrl.src_b     = SRC_B_IMM;
        ctrl.reg_write = 1'b1;
        ctrl.imm       = imm_i(instr);
        case (funct3)
          3'b001: begin
            ctrl.alu_control = ALU_SLL;
            ctrl.imm         = imm_shamt(instr);
            if (funct7 != F7_BASE) illegal = 1'b1;
          end
          3'b101: begin
            ctrl.alu_control = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            ctrl.imm         = imm_shamt(instr);
            if (funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
          end
          default: ctrl.alu_control = {1'b0, funct3};
        endcase
      end

      OPC_LOAD: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.src_b       = SRC_B_IMM;
        ctrl.imm         = imm_i(instr);
        ctrl.mem_read    = 1'b1;
        ctrl.result_src  = RES_MEM;
        ctrl.reg_write   = 1'b1;
      end

      OPC_STORE: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.src_b       = SRC_B_IMM;
        ctrl.imm         = imm_s(instr);
        ctrl.mem_write   = 1'b1;
      end

      OPC_BRANCH: begin
        ctrl.src_b      = SRC_B_RS2;
        ctrl.imm        = imm_b(instr);
        ctrl.branch     = 1'b1;
        // funct3[0] always selects the negated sense (BNE/BGE/BGEU).
        ctrl.branch_inv = funct3[0];
        case (funct3[2:1])
          2'b00:   ctrl.alu_control = ALU_SUB;
          2'b10:   ctrl.alu_control = ALU_SLT;
          2'b11:   ctrl.alu_control = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end

      OPC_JAL: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.src_a       = SRC_A_PC;
        ctrl.src_b       = SRC_B_IMM;
        ctrl.imm         = imm_j(instr);
        ctrl.jump        = 1'b1;
        ctrl.result_src  = RES_PC4;
        ctrl.reg_write   = 1'b1;
      end

      OPC_JALR: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.src_a       = SRC_A_RS1;
        ctrl.src_b       = SRC_B_IMM;
        ctrl.imm         = imm_i(instr);
        ctrl.jump        = 1'b1;
        ctrl.result_src  = RES_PC4;
        ctrl.reg_write   = 1'b1;
        if (funct3 != 3'b000) illegal = 1'b1;
      end

      OPC_LUI: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.src_a       = SRC_A_ZERO;
        ctrl.src_b       = SRC_B_IMM;
        ctrl.imm         = imm_u(instr);
        ctrl.reg_write   = 1'b1;
      end

      OPC_AUIPC: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.src_a       = SRC_A_PC;
        ctrl.src_b       = SRC_B_IMM;
        ctrl.imm         = imm_u(instr);
        ctrl.reg_write   = 1'b1;
      end

      default: illegal = 1'b1;
    endcase

    // Illegal encodings travel down the pipe as inert bubbles flagged for a trap.
    if (illegal) begin
      ctrl.alu_control = ALU_ADD;
      ctrl.src_a       = SRC_A_RS1;
      ctrl.src_b       = SRC_B_RS2;
      ctrl.imm         = '0;
      ctrl.reg_write   = 1'b0;
      ctrl.result_src  = RES_ALU;
      ctrl.mem_read    = 1'b0;
      ctrl.mem_write   = 1'b0;
      ctrl.branch      = 1'b0;
      ctrl.branch_inv  = 1'b0;
      ctrl.jump        = 1'b0;
    end
    ctrl.illegal = illegal;

    if (ctrl.rd == 5'd0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// ID/EX pipeline register around alu_ctrl_decode with valid/ready handshake and flush.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [31:0]        instr_i,
  input  logic [D_WIDTH-1:0] pc_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [3:0]         alu_control_o,
  output logic [1:0]         src_a_sel_o,
  output logic               src_b_sel_o,
  output logic [D_WIDTH-1:0] imm_o,
  output logic [D_WIDTH-1:0] pc_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [4:0]         rd_o,
  output logic               reg_write_o,
  output logic [1:0]         result_src_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               branch_o,
  output logic               branch_inv_o,
  output logic               jump_o,
  output logic               illegal_o
);

  ctrl_t dec_ctrl;
  ctrl_t next_ctrl;
  ctrl_t stage_q;
  logic  valid_q;
  logic  load;

  alu_ctrl_decode u_decode (
    .instr (instr_i),
    .ctrl  (dec_ctrl)
  );

  always_comb begin
    next_ctrl    = dec_ctrl;
    next_ctrl.pc = pc_i;
  end

  assign ready_o = !valid_q || ready_i;
  assign load    = valid_i && ready_o;

  // Flush wins over a simultaneous load; the payload is only written on a surviving load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
      if (load && !flush_i) begin
        stage_q <= next_ctrl;
      end
    end
  end

  assign valid_o       = valid_q;
  assign alu_control_o = stage_q.alu_control;
  assign src_a_sel_o   = stage_q.src_a;
  assign src_b_sel_o   = stage_q.src_b;
  assign imm_o         = stage_q.imm;
  assign pc_o          = stage_q.pc;
  assign rs1_o         = stage_q.rs1;
  assign rs2_o         = stage_q.rs2;
  assign rd_o          = stage_q.rd;
  assign reg_write_o   = stage_q.reg_write;
  assign result_src_o  = stage_q.result_src;
  assign mem_read_o    = stage_q.mem_read;
  assign mem_write_o   = stage_q.mem_write;
  assign branch_o      = stage_q.branch;
  assign branch_inv_o  = stage_q.branch_inv;
  assign jump_o        = stage_q.jump;
  assign illegal_o     = stage_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed test-plan steps plus randomized
// traffic scored against an instruction-level reference model.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  alu_control_o;
  logic [1:0]  src_a_sel_o;
  logic        src_b_sel_o;
  logic [31:0] imm_o;
  logic [31:0] pc_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        reg_write_o;
  logic [1:0]  result_src_o;
  logic        mem_read_o, mem_write_o, branch_o, branch_inv_o, jump_o, illegal_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  alu;
    logic [1:0]  src_a;
    logic        src_b;
    logic [31:0] imm;
    logic        imm_care;
    logic        sel_care;
    logic        rw;
    logic [1:0]  rsrc;
    logic        mr, mw, br, binv, jmp, ill;
  } exp_t;

  logic        sb_valid;
  exp_t        sb_exp;
  logic [31:0] sb_instr;
  logic [31:0] sb_pc;

  alu_decode_stage #(.D_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .flush_i       (flush_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .alu_control_o (alu_control_o),
    .src_a_sel_o   (src_a_sel_o),
    .src_b_sel_o   (src_b_sel_o),
    .imm_o         (imm_o),
    .pc_o          (pc_o),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o),
    .rd_o          (rd_o),
    .reg_write_o   (reg_write_o),
    .result_src_o  (result_src_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .branch_o      (branch_o),
    .branch_inv_o  (branch_inv_o),
    .jump_o        (jump_o),
    .illegal_o     (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Reference model: immediates built with signed arithmetic shifts on the whole word.
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    logic signed [31:0] s;
    logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm, sh;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    s     = $signed(ins);
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    i_imm = 32'(s >>> 20);
    s_imm = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
    b_imm = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    j_imm = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    u_imm = ins & 32'hFFFF_F000;
    sh    = 32'(ins[24:20]);
    e = '{alu: 4'd0, src_a: 2'd0, src_b: 1'b0, imm: 32'd0, imm_care: 1'b1, sel_care: 1'b1,
          rw: 1'b0, rsrc: 2'd0, mr: 1'b0, mw: 1'b0, br: 1'b0, binv: 1'b0, jmp: 1'b0, ill: 1'b0};
    case (opc)
      7'h33: begin
        e.imm_care = 1'b0;
        e.rw = 1'b1;
        if (f7 == 7'h00) e.alu = {1'b0, f3};
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu = {1'b1, f3};
        else e.ill = 1'b1;
      end
      7'h13: begin
        e.src_b = 1'b1;
        e.rw = 1'b1;
        if (f3 == 3'd1) begin
          e.alu = 4'd1; e.imm = sh;
          if (f7 != 7'h00) e.ill = 1'b1;
        end else if (f3 == 3'd5) begin
          e.alu = (f7 == 7'h20) ? 4'd13 : 4'd5; e.imm = sh;
          if (f7 != 7'h00 && f7 != 7'h20) e.ill = 1'b1;
        end else begin
          e.alu = {1'b0, f3}; e.imm = i_imm;
        end
      end
      7'h03: begin e.src_b = 1'b1; e.imm = i_imm; e.mr = 1'b1; e.rsrc = 2'd1; e.rw = 1'b1; end
      7'h23: begin e.src_b = 1'b1; e.imm = s_imm; e.mw = 1'b1; end
      7'h63: begin
        e.br = 1'b1; e.imm = b_imm;
        case (f3)
          3'd0: begin e.alu = 4'd8; e.binv = 1'b0; end
          3'd1: begin e.alu = 4'd8; e.binv = 1'b1; end
          3'd4: begin e.alu = 4'd2; e.binv = 1'b0; end
          3'd5: begin e.alu = 4'd2; e.binv = 1'b1; end
          3'd6: begin e.alu = 4'd3; e.binv = 1'b0; end
          3'd7: begin e.alu = 4'd3; e.binv = 1'b1; end
          default: e.ill = 1'b1;
        endcase
      end
      7'h6F: begin e.src_a = 2'd1; e.src_b = 1'b1; e.imm = j_imm; e.jmp = 1'b1; e.rsrc = 2'd2; e.rw = 1'b1; end
      7'h67: begin
        e.src_b = 1'b1; e.imm = i_imm; e.jmp = 1'b1; e.rsrc = 2'd2; e.rw = 1'b1;
        if (f3 != 3'd0) e.ill = 1'b1;
      end
      7'h37: begin e.src_a = 2'd2; e.src_b = 1'b1; e.imm = u_imm; e.rw = 1'b1; end
      7'h17: begin e.src_a = 2'd1; e.src_b = 1'b1; e.imm = u_imm; e.rw = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.alu = 4'd0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.binv = 1'b0; e.jmp = 1'b0;
      e.imm_care = 1'b0; e.sel_care = 1'b0;
    end
    if (ins[11:7] == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  task automatic compare_outputs();
    chk("valid_o", 32'(valid_o), 32'(sb_valid));
    if (sb_valid) begin
      chk("alu_control", 32'(alu_control_o), 32'(sb_exp.alu));
      chk("pc", pc_o, sb_pc);
      chk("rs1", 32'(rs1_o), 32'(sb_instr[19:15]));
      chk("rs2", 32'(rs2_o), 32'(sb_instr[24:20]));
      chk("rd", 32'(rd_o), 32'(sb_instr[11:7]));
      chk("reg_write", 32'(reg_write_o), 32'(sb_exp.rw));
      chk("mem_read", 32'(mem_read_o), 32'(sb_exp.mr));
      chk("mem_write", 32'(mem_write_o), 32'(sb_exp.mw));
      chk("branch", 32'(branch_o), 32'(sb_exp.br));
      chk("branch_inv", 32'(branch_inv_o), 32'(sb_exp.binv));
      chk("jump", 32'(jump_o), 32'(sb_exp.jmp));
      chk("illegal", 32'(illegal_o), 32'(sb_exp.ill));
      if (sb_exp.imm_care) chk("imm", imm_o, sb_exp.imm);
      if (sb_exp.sel_care) begin
        chk("src_a_sel", 32'(src_a_sel_o), 32'(sb_exp.src_a));
        chk("src_b_sel", 32'(src_b_sel_o), 32'(sb_exp.src_b));
        chk("result_src", 32'(result_src_o), 32'(sb_exp.rsrc));
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic r, input logic f);
    valid_i = v;
    instr_i = ins;
    ready_i = r;
    flush_i = f;
    pc_i    = $urandom;
  endtask

  // One clock: check ready_o before the edge, advance the scoreboard, check after.
  task automatic checkOutput();
    #1;
    chk("ready_o", 32'(ready_o), 32'(!sb_valid || ready_i));
    @(posedge clk);
    if (flush_i) begin
      sb_valid = 1'b0;
    end else if (valid_i && (!sb_valid || ready_i)) begin
      sb_valid = 1'b1;
      sb_exp   = ref_decode(instr_i);
      sb_instr = instr_i;
      sb_pc    = pc_i;
    end else if (ready_i) begin
      sb_valid = 1'b0;
    end
    #1;
    compare_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [10];
    logic [31:0] ins;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    ins = $urandom;
    ins[6:0] = opcs[$urandom_range(0, 9)];
    if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && ($urandom_range(0, 3) != 0))
      ins[31:25] = ins[30] ? 7'h20 : 7'h00;
    return ins;
  endfunction

  initial begin
    sb_valid = 1'b0;
    sb_instr = '0;
    sb_pc    = '0;
    sb_exp   = ref_decode(32'h0000_0013);
    rst_n    = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset alu_control", 32'(alu_control_o), 32'd0);
    chk("reset imm", imm_o, 32'd0);
    chk("reset pc", pc_o, 32'd0);
    chk("reset rd", 32'(rd_o), 32'd0);
    chk("reset reg_write", 32'(reg_write_o), 32'd0);
    chk("reset ready_o", 32'(ready_o), 32'd1);
    rst_n = 1'b1;

    // SUB x3,x1,x2
    applyStimulus(1'b1, 32'h402081B3, 1'b1, 1'b0);
    checkOutput();
    chk("sub valid", 32'(valid_o), 32'd1);
    chk("sub alu", 32'(alu_control_o), 32'h8);
    chk("sub src_b", 32'(src_b_sel_o), 32'd0);
    chk("sub rd", 32'(rd_o), 32'd3);
    chk("sub reg_write", 32'(reg_write_o), 32'd1);

    // SRAI x5,x6,3 then ADDI x1,x0,-1
    applyStimulus(1'b1, 32'h40335293, 1'b1, 1'b0);
    checkOutput();
    chk("srai alu", 32'(alu_control_o), 32'hD);
    chk("srai src_b", 32'(src_b_sel_o), 32'd1);
    chk("srai imm", imm_o, 32'd3);
    applyStimulus(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    checkOutput();
    chk("addi alu", 32'(alu_control_o), 32'h0);
    chk("addi imm", imm_o, 32'hFFFF_FFFF);

    // BGE x1,x2,+8 then BEQ x1,x2,+8
    applyStimulus(1'b1, 32'h0020D463, 1'b1, 1'b0);
    checkOutput();
    chk("bge alu", 32'(alu_control_o), 32'h2);
    chk("bge branch", 32'(branch_o), 32'd1);
    chk("bge inv", 32'(branch_inv_o), 32'd1);
    chk("bge imm", imm_o, 32'd8);
    chk("bge reg_write", 32'(reg_write_o), 32'd0);
    applyStimulus(1'b1, 32'h00208463, 1'b1, 1'b0);
    checkOutput();
    chk("beq alu", 32'(alu_control_o), 32'h8);
    chk("beq inv", 32'(branch_inv_o), 32'd0);

    // Stall: SUB held for three cycles while SRAI waits upstream.
    applyStimulus(1'b1, 32'h402081B3, 1'b1, 1'b0);
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h40335293, 1'b0, 1'b0);
      pc_i = 32'h0000_1000;
      checkOutput();
      chk("stall ready_o", 32'(ready_o), 32'd0);
      chk("stall alu", 32'(alu_control_o), 32'h8);
      chk("stall rd", 32'(rd_o), 32'd3);
    end
    ready_i = 1'b1;
    checkOutput();
    chk("unstall alu", 32'(alu_control_o), 32'hD);
    chk("unstall pc", pc_o, 32'h0000_1000);

    // Flush on a load cycle.
    applyStimulus(1'b1, 32'h00508013, 1'b1, 1'b1);
    checkOutput();
    chk("flush valid", 32'(valid_o), 32'd0);

    // Async reset in the middle of a hold.
    applyStimulus(1'b1, 32'h402081B3, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 32'h00208463, 1'b0, 1'b0);
    checkOutput();
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(valid_o), 32'd0);
    chk("async reset alu", 32'(alu_control_o), 32'd0);
    sb_valid = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput();

    // Illegal encodings and rd=x0.
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    checkOutput();
    chk("ill all-ones", 32'(illegal_o), 32'd1);
    chk("ill all-ones valid", 32'(valid_o), 32'd1);
    chk("ill all-ones mem_write", 32'(mem_write_o), 32'd0);
    applyStimulus(1'b1, 32'h40009093, 1'b1, 1'b0);
    checkOutput();
    chk("ill slli", 32'(illegal_o), 32'd1);
    chk("ill slli reg_write", 32'(reg_write_o), 32'd0);
    applyStimulus(1'b1, 32'h00508013, 1'b1, 1'b0);
    checkOutput();
    chk("addi x0 reg_write", 32'(reg_write_o), 32'd0);
    chk("addi x0 illegal", 32'(illegal_o), 32'd0);

    // Randomized traffic with random handshake and occasional flush.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0);
      checkOutput();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- ID/EX pipeline stage that produces the ALU's control interface: the 4-bit ALUControl code plus operand selects, immediate and writeback/branch control.
- Decodes the RV32I base instruction set. Registers the result with a valid/ready handshake and a flush.
- Sits between fetch/regfile read and the execute stage. The ALU consumes alu_control_o directly.

Parameters:
D_WIDTH, 32, datapath/immediate/PC width (only 32 supported)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  instr_i/pc_i valid from fetch
ready_o  output  1  stage can accept
instr_i  input  32  raw instruction
pc_i  input  D_WIDTH  instruction address
flush_i  input  1  kill held and incoming instruction
valid_o  output  1  registered outputs valid
ready_i  input  1  execute accepts
alu_control_o  output  4  {bit3 sub/sra, [2:0] op}; 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and
src_a_sel_o  output  2  0 rs1, 1 pc, 2 zero
src_b_sel_o  output  1  0 rs2, 1 imm
imm_o  output  D_WIDTH  sign-extended immediate
pc_o  output  D_WIDTH  pc passthrough
rs1_o, rs2_o, rd_o  output  5 each  register indices
reg_write_o  output  1  writeback enable
result_src_o  output  2  0 ALU, 1 memory, 2 pc+4
mem_read_o, mem_write_o  output  1 each  load/store
branch_o  output  1  conditional branch
branch_inv_o  output  1  take branch when Zero==0
jump_o  output  1  JAL/JALR
illegal_o  output  1  unsupported encoding

Behaviour:
- Reset (async, rst_n low): valid_o=0 and every control output 0 (alu_control_o=0000, imm_o=0, pc_o=0). Index fields are 0.
- ready_o = !valid_o || ready_i. This path is combinational and is the only one.
- Load condition: valid_i && ready_o. When it holds, the decode of instr_i/pc_i is registered and valid_o=1 next cycle. Latency is 1 cycle.
- Hold: valid_o && !ready_i keeps every output bit-stable.
- Drain: ready_i && !valid_i clears valid_o. Payload may stay stale.
- flush_i has top priority. valid_o=0 next cycle even on a simultaneous load.
- Decode by opcode:
  - R-type (0110011): op=funct3; bit3=instr[30]. bit3=1 is legal only for funct3 000/101. Any funct7 other than 0000000/0100000 is illegal.
  - I-ALU (0010011): op=funct3; src_b=imm. bit3=instr[30] only for funct3=101. ADDI never subtracts. SLLI needs funct7=0000000. SRLI/SRAI need 0000000/0100000.
  - LOAD/STORE: ADD, src_b=imm. LOAD also sets mem_read and result_src=1, reg_write=1. STORE sets mem_write, reg_write=0.
  - BRANCH: branch_o=1, src_b=rs2, imm=B-imm.
    - BEQ/BNE: 1000. Zero is equality; branch_inv=0/1.
    - BLT/BGE: 0010. Zero carries the less-than result; inv=0/1.
    - BLTU/BGEU: 0011; inv=0/1.
    - funct3 010/011 are illegal.
  - JAL: src_a=pc, src_b=imm (J-imm), ADD, jump_o=1, result_src=2.
  - JALR: src_a=rs1, I-imm, funct3 must be 000, jump_o=1, result_src=2.
  - LUI: src_a=zero, imm=U-imm, ADD.
  - AUIPC: src_a=pc, U-imm, ADD.
  - Any other opcode is illegal.
- Immediates: I/S/B/J are sign-extended from bit 31. B and J have bit0=0. U-imm is {instr[31:12],12'b0}.
- rd=x0 forces reg_write_o=0.
- Illegal instructions: still registered with valid_o=1 and illegal_o=1. reg_write, mem_*, branch and jump are all 0, and alu_control_o=0000.

Decomposition:
- Shared package alu_pkg holds:
  - ALUControl localparams: ALU_ADD=0000, ALU_SUB=1000, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND.
  - Opcode constants.
  - src_a/src_b/result_src enums.
  - Packed struct ctrl_t bundling all registered fields.
- Sub-module alu_ctrl_decode is pure combinational: instr -> ctrl_t. The top level holds only the pipeline register, handshake and flush.

Test Plan:
- SUB x3,x1,x2 (0x402081B3), valid_i=1, ready_i=1 -> next cycle valid_o=1, alu_control=1000, src_b=0, rd=3, reg_write=1.
- SRAI x5,x6,3 (0x40335293) -> alu_control=1101, src_b=1, imm=3. ADDI x1,x0,-1 (0xFFF00093) -> alu_control=0000, imm=0xFFFFFFFF.
- BGE x1,x2,+8 -> alu_control=0010, branch_o=1, branch_inv=1, imm=8, reg_write=0. BEQ -> 1000, inv=0.
- Stall: valid_o=1, ready_i=0 for 3 cycles while valid_i=1 -> ready_o=0, outputs unchanged. ready_i=1 -> new instruction appears next cycle.
- flush_i=1 same cycle as a load -> valid_o=0 next cycle. rst_n low mid-hold -> valid_o=0 immediately (async).
- instr 0xFFFFFFFF and SLLI with funct7=0100000 -> illegal_o=1, valid_o=1, reg_write=0, mem_write=0. ADDI rd=x0 -> reg_write=0.
